// File: rtl/stereo_ser_pkg.sv
// Shared types for the stereo serializer: output FSM states,
// underrun counter width and its saturating increment.
package stereo_ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } ser_state_e;

  localparam int unsigned UNDERRUN_CNT_W = 16;

  function automatic logic [UNDERRUN_CNT_W-1:0] sat_inc(
    input logic [UNDERRUN_CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/stereo_frame_buf.sv
// One-entry stereo frame buffer with full flag.
// ready_o is taken from the registered flag only.
module stereo_frame_buf
  import stereo_ser_pkg::*;
#(
  parameter int width_p = 24
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [2*width_p-1:0]   data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   take_i,
  output logic [2*width_p-1:0]   frame_o,
  output logic                   full_o
);

  logic                 full_q;
  logic [2*width_p-1:0] frame_q;

  assign ready_o = !full_q;
  assign full_o  = full_q;
  assign frame_o = frame_q;

  // Capture a frame when empty; a drain empties the slot.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      full_q  <= 1'b0;
      frame_q <= '0;
    end else if (valid_i && !full_q) begin
      full_q  <= 1'b1;
      frame_q <= data_i;
    end else if (take_i) begin
      full_q  <= 1'b0;
    end
  end

endmodule

// File: rtl/stereo_serializer.sv
// Stereo frame to left/right word serializer.
// Optional underrun counter: define STEREO_SER_UNDERRUN_CNT_EN.
module stereo_serializer
  import stereo_ser_pkg::*;
#(
  parameter int width_p = 24
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [2*width_p-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [width_p-1:0]   data_o,
  output logic                 last_o,
  output logic                 valid_o,
  input  logic                 ready_i
`ifdef STEREO_SER_UNDERRUN_CNT_EN
  ,
  output logic [UNDERRUN_CNT_W-1:0] underrun_count_o
`endif
);

  logic [2*width_p-1:0] buf_frame;
  logic                 buf_full;
  logic                 take;
  ser_state_e           state_q;
  logic [width_p-1:0]   right_q;

  // Buffer drains on an IDLE pickup or a RIGHT word handoff.
  assign take = buf_full &&
                ((state_q == ST_IDLE) ||
                 ((state_q == ST_RIGHT) && ready_i));

  stereo_frame_buf #(
    .width_p (width_p)
  ) u_buf (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (data_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .take_i  (take),
    .frame_o (buf_frame),
    .full_o  (buf_full)
  );

  // Output FSM: left word loads straight into data_o,
  // right half is parked in right_q for the next word.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      right_q <= '0;
      data_o  <= '0;
      last_o  <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (take) begin
            state_q <= ST_LEFT;
            right_q <= buf_frame[2*width_p-1:width_p];
            data_o  <= buf_frame[width_p-1:0];
            last_o  <= 1'b0;
            valid_o <= 1'b1;
          end
        end
        ST_LEFT: begin
          if (ready_i) begin
            state_q <= ST_RIGHT;
            data_o  <= right_q;
            last_o  <= 1'b1;
          end
        end
        ST_RIGHT: begin
          if (ready_i) begin
            if (take) begin
              state_q <= ST_LEFT;
              right_q <= buf_frame[2*width_p-1:width_p];
              data_o  <= buf_frame[width_p-1:0];
              last_o  <= 1'b0;
              valid_o <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              data_o  <= '0;
              last_o  <= 1'b0;
              valid_o <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          data_o  <= '0;
          last_o  <= 1'b0;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef STEREO_SER_UNDERRUN_CNT_EN
  logic                      started_q;
  logic [UNDERRUN_CNT_W-1:0] ucnt_q;

  // Count idle cycles with a willing sink once traffic began.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      started_q <= 1'b0;
      ucnt_q    <= '0;
    end else begin
      if (valid_o && ready_i)
        started_q <= 1'b1;
      if ((state_q == ST_IDLE) && ready_i && started_q)
        ucnt_q <= sat_inc(ucnt_q);
    end
  end

  assign underrun_count_o = ucnt_q;
`endif

endmodule

// File: doc/stereo_serializer.md
STEREO_SERIALIZER -- requirements
Module: stereo_serializer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk_i and reset_i.
REQ-002 Parameter width_p SHALL default to 24 and set the sample width per channel.
REQ-003 Port clk_i SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-004 Port reset_i SHALL be an input, 1 bit wide: asynchronous, active-high reset.
REQ-005 Port data_i SHALL be an input, 2*width_p bits wide: stereo frame; [width_p-1:0] is left, [2*width_p-1:width_p] is right.
REQ-006 Port valid_i SHALL be an input, 1 bit wide: upstream frame valid.
REQ-007 Port ready_o SHALL be an output, 1 bit wide: the block can accept a frame.
REQ-008 Port data_o SHALL be an output, width_p bits wide: serialized channel sample.
REQ-009 Port last_o SHALL be an output, 1 bit wide: 1 on the right word, 0 on the left word.
REQ-010 Port valid_o SHALL be an output, 1 bit wide: data_o and last_o are valid.
REQ-011 Port ready_i SHALL be an input, 1 bit wide: downstream accepts the word.
REQ-012 Port underrun_count_o SHALL be an output, 16 bits wide, present only under STEREO_SER_UNDERRUN_CNT_EN.

Function
REQ-013 A frame SHALL transfer when valid_i && ready_o are high on a rising edge; a word SHALL transfer when valid_o && ready_i are high.
REQ-014 The block SHALL hold a one-entry frame buffer with a full flag; ready_o SHALL equal !full, combinationally from the flag only.
REQ-015 The output FSM SHALL have three states: IDLE (valid_o=0), LEFT (data_o=left, last_o=0) and RIGHT (data_o=right, last_o=1), serving the current-frame register.
REQ-016 In IDLE with the buffer full, the FSM SHALL move the buffer into the current-frame register, clear full and go to LEFT.
REQ-017 In LEFT with ready_i high, the FSM SHALL go to RIGHT; with ready_i low, it SHALL stay in LEFT.
REQ-018 In RIGHT with ready_i high: if the buffer is full, the FSM SHALL reload the current-frame register, clear full and go to LEFT; otherwise it SHALL go to IDLE; with ready_i low, it SHALL stay in RIGHT.
REQ-019 Latency SHALL be 2 cycles: for a frame accepted at the edge ending cycle N into an empty block, the left word SHALL be valid in cycle N+2.
REQ-020 With valid_i and ready_i held high, throughput SHALL be one word per cycle with no bubbles after the first word.
REQ-021 While valid_o is high and ready_i is low, data_o, last_o and valid_o SHALL hold stable.
REQ-022 A frame offered while the buffer is full SHALL be ignored, and the upstream holds it.
REQ-023 A simultaneous buffer drain (REQ-016/018) and an upstream offer SHALL NOT accept in the same cycle, because ready_o derives from the registered flag.
REQ-024 Channel order SHALL always be left then right; frames SHALL never be dropped, duplicated or reordered.

Reset
REQ-025 Asserting reset_i at any time, including mid-frame, SHALL asynchronously force state=IDLE, full=0, valid_o=0, last_o=0, data_o=0 and underrun_count_o=0, discarding any buffered frames.
REQ-026 ready_o SHALL read 1 during and after reset.

Configuration
REQ-027 With macro STEREO_SER_UNDERRUN_CNT_EN defined, the block SHALL set a sticky started flag on the first word transfer.
REQ-028 With STEREO_SER_UNDERRUN_CNT_EN defined, underrun_count_o SHALL increment each cycle that state=IDLE && ready_i && started, saturating at 16'hFFFF.
REQ-029 Without STEREO_SER_UNDERRUN_CNT_EN, the port, flag and counter SHALL be absent, with all other behaviour identical.

Structure
REQ-030 Shared package stereo_ser_pkg SHALL hold the FSM state enum typedef and the underrun counter width constant (16).
REQ-031 The frame buffer and full flag SHALL be a sub-module named stereo_frame_buf; the FSM and output register SHALL be in stereo_serializer.

Verification (width_p=24)
REQ-032 The bench SHALL pulse reset_i while in RIGHT with the buffer full; valid_o SHALL drop to 0 without a clock edge, ready_o SHALL be 1 after release, and no stale word SHALL appear.
REQ-033 The bench SHALL send one frame with left=0x000001 and right=0x800000 at cycle N with ready_i=1; the response SHALL be N+2: 0x000001/last 0, then N+3: 0x800000/last 1, then N+4: valid_o=0.
REQ-034 The bench SHALL hold valid_i high for four frames (L=k, R=0x100+k, k=1..4) with ready_i=1; the response SHALL be 8 consecutive words 1,0x101,2,0x102,... with last alternating 0/1 and no gaps.
REQ-035 The bench SHALL hold ready_i=0 for 5 cycles in LEFT with data 0x123456 while a second frame is offered; data_o SHALL stay 0x123456, valid_o SHALL stay 1, the buffer SHALL fill, ready_o SHALL read 0, and order SHALL be preserved after release.
REQ-036 With the macro defined, the bench SHALL send one frame, then idle 10 cycles with ready_i=1; underrun_count_o SHALL read 10, and after 70000 idle cycles it SHALL read 0xFFFF.
